// File: rtl/axim_bridge_pkg.sv
// Shared definitions for the LSU-to-AXI4-Lite bridge.
//  - AXI4-Lite response codes and the default protection value
//  - bridge FSM state encoding
//  - helper that classifies an AXI response as an error
package axim_bridge_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WREQ = 3'd1,
    ST_WRSP = 3'd2,
    ST_RREQ = 3'd3,
    ST_RRSP = 3'd4,
    ST_DONE = 3'd5
  } bridge_state_e;

  // Anything other than OKAY is reported to the LSU as an error
  // (EXOKAY is meaningless for a non-exclusive AXI4-Lite access).
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axim_bridge_tmo.sv
// Response timeout counter for the bridge.
//  clk, rst_n : clock, asynchronous active-low reset
//  clr        : hold the count at zero (asserted whenever not waiting for a response)
//  en         : count one waiting cycle
//  expired    : count has reached TIMEOUT-1; constant 0 when TIMEOUT == 0
module axim_tmo #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // TIMEOUT == 0 disables expiry entirely.
  assign expired = (TIMEOUT != 0) && en && (cnt_reg == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/axim_bridge.sv
// LSU off-SRAM request port to AXI4-Lite master bridge.
// Accepts one request on hs_ls4axim_val, runs exactly one AXI4-Lite read or write,
// and reports completion with a one-cycle hs_axim4ls_rdy pulse carrying o_rdat/o_err.
// Ports:
//  clk, rst_n                        clock, asynchronous active-low reset
//  hs_ls4axim_val / hs_axim4ls_rdy   request valid in / completion pulse out
//  i_adr, i_wdat, i_wen              request address, write data, byte strobes (0 = read)
//  o_rdat, o_err                     read data (0 for writes/timeouts), error flag
//  o_aw*/i_awready, o_w*/i_wready    AXI write address / write data channels
//  i_bvalid/o_bready, i_bresp        AXI write response channel
//  o_ar*/i_arready                   AXI read address channel
//  i_rvalid/o_rready, i_rdata/i_rresp AXI read data channel
module axim_bridge
  import axim_bridge_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_ls4axim_val,
  output logic        hs_axim4ls_rdy,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  input  logic [3:0]  i_wen,
  output logic [31:0] o_rdat,
  output logic        o_err,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [31:0] o_awaddr,
  output logic [2:0]  o_awprot,
  output logic        o_wvalid,
  input  logic        i_wready,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  input  logic        i_bvalid,
  output logic        o_bready,
  input  logic [1:0]  i_bresp,
  output logic        o_arvalid,
  input  logic        i_arready,
  output logic [31:0] o_araddr,
  output logic [2:0]  o_arprot,
  input  logic        i_rvalid,
  output logic        o_rready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp
);

  bridge_state_e state_reg;
  logic [31:0]   adr_reg;
  logic [31:0]   wdat_reg;
  logic [3:0]    wen_reg;

  logic tmo_clr;
  logic tmo_expired;
  logic aw_fin;
  logic w_fin;

  // Counter runs only while waiting for B or R; every other state holds it at zero,
  // so it is always cleared on entry to WRSP/RRSP.
  assign tmo_clr = (state_reg != ST_WRSP) && (state_reg != ST_RRSP);

  axim_tmo #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (!tmo_clr),
    .expired (tmo_expired)
  );

  // A channel is finished once its valid has dropped, or in the cycle its handshake occurs.
  assign aw_fin = !o_awvalid || i_awready;
  assign w_fin  = !o_wvalid  || i_wready;

  assign o_awaddr = adr_reg;
  assign o_araddr = adr_reg;
  assign o_awprot = AXI_PROT_DEFAULT;
  assign o_arprot = AXI_PROT_DEFAULT;
  assign o_wdata  = wdat_reg;
  assign o_wstrb  = wen_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      adr_reg        <= '0;
      wdat_reg       <= '0;
      wen_reg        <= '0;
      o_rdat         <= '0;
      o_err          <= 1'b0;
      hs_axim4ls_rdy <= 1'b0;
      o_awvalid      <= 1'b0;
      o_wvalid       <= 1'b0;
      o_bready       <= 1'b0;
      o_arvalid      <= 1'b0;
      o_rready       <= 1'b0;
    end else begin
      hs_axim4ls_rdy <= 1'b0;

      // After a timeout the ready is left high so a late response is swallowed;
      // it drops once that response has been taken.
      if (o_bready && i_bvalid && (state_reg != ST_WRSP)) o_bready <= 1'b0;
      if (o_rready && i_rvalid && (state_reg != ST_RRSP)) o_rready <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (hs_ls4axim_val) begin
            adr_reg  <= i_adr;
            wdat_reg <= i_wdat;
            wen_reg  <= i_wen;
            if (i_wen != 4'b0000) begin
              state_reg <= ST_WREQ;
              o_awvalid <= 1'b1;
              o_wvalid  <= 1'b1;
            end else begin
              state_reg <= ST_RREQ;
              o_arvalid <= 1'b1;
            end
          end
        end

        ST_WREQ: begin
          if (o_awvalid && i_awready) o_awvalid <= 1'b0;
          if (o_wvalid && i_wready)   o_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            state_reg <= ST_WRSP;
            o_bready  <= 1'b1;
          end
        end

        ST_WRSP: begin
          if (i_bvalid) begin
            o_err          <= resp_is_err(i_bresp);
            o_rdat         <= '0;
            o_bready       <= 1'b0;
            hs_axim4ls_rdy <= 1'b1;
            state_reg      <= ST_DONE;
          end else if (tmo_expired) begin
            o_err          <= 1'b1;
            o_rdat         <= '0;
            hs_axim4ls_rdy <= 1'b1;
            state_reg      <= ST_DONE;
          end
        end

        ST_RREQ: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state_reg <= ST_RRSP;
          end
        end

        ST_RRSP: begin
          if (i_rvalid) begin
            o_rdat         <= i_rdata;
            o_err          <= resp_is_err(i_rresp);
            o_rready       <= 1'b0;
            hs_axim4ls_rdy <= 1'b1;
            state_reg      <= ST_DONE;
          end else if (tmo_expired) begin
            o_rdat         <= '0;
            o_err          <= 1'b1;
            hs_axim4ls_rdy <= 1'b1;
            state_reg      <= ST_DONE;
          end
        end

        // hs_axim4ls_rdy is high for this single cycle; requests are not sampled here.
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
